// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// frame bit indices and the sample-point offset.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [3:0] BIT_START     = 4'd0;
  localparam logic [3:0] BIT_DATA_LAST = 4'd8;
  localparam logic [3:0] BIT_PARITY    = 4'd9;

  // Majority votes land at P/2-1..P/2+1, so the voted bit is stable at P/2+2.
  localparam int SAMPLE_OFFSET = 2;

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; cleared synchronously
// whenever the controller deasserts enable.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  w_bit_done;

  assign w_bit_done = (r_edge_cnt == (Prescale - {{(PRESCALE_W-1){1'b0}}, 1'b1}));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_edge_cnt <= {PRESCALE_W{1'b0}};
      r_bit_cnt  <= BIT_START;
    end else if (!enable) begin
      r_edge_cnt <= {PRESCALE_W{1'b0}};
      r_bit_cnt  <= BIT_START;
    end else if (w_bit_done) begin
      r_edge_cnt <= {PRESCALE_W{1'b0}};
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      r_bit_cnt  <= r_bit_cnt;
    end
  end

  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;
  assign bit_done = w_bit_done;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: frames start/data/parity/stop bits, strobes the
// sampler, deserializer and checkers, and flags each error-free frame.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid
);

  rx_state_e             r_state;
  rx_state_e             w_next_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  w_cnt_en;
  logic                  w_bit_done;
  logic [PRESCALE_W-1:0] w_samp_pre;
  logic                  w_at_samp_pre;
  logic                  w_dat_samp_en, w_strt_chk_en, w_par_chk_en;
  logic                  w_stp_chk_en, w_deser_en, w_data_valid;
  logic                  r_dat_samp_en, r_strt_chk_en, r_par_chk_en;
  logic                  r_stp_chk_en, r_deser_en, r_data_valid;

  // Any entry into START (from IDLE or back-to-back from STOP) restarts the counters at zero.
  assign w_cnt_en = (w_next_state != ST_IDLE) &&
                    !((w_next_state == ST_START) && (r_state != ST_START));

  edge_bit_counter #(.PRESCALE_W(PRESCALE_W)) u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (w_cnt_en),
    .Prescale (r_prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (w_bit_done)
  );

  // Strobes are registered, so they are decoded one edge before the sample point.
  assign w_samp_pre    = (r_prescale >> 1) + PRESCALE_W'(SAMPLE_OFFSET - 1);
  assign w_at_samp_pre = (edge_cnt == w_samp_pre);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_prescale <= {PRESCALE_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && (w_next_state == ST_START)) begin
        r_prescale <= Prescale;
      end else begin
        r_prescale <= r_prescale;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!RX_IN) w_next_state = ST_START;
        else        w_next_state = ST_IDLE;
      end
      ST_START: begin
        if (w_bit_done) w_next_state = strt_glitch ? ST_IDLE : ST_DATA;
        else            w_next_state = ST_START;
      end
      ST_DATA: begin
        if (w_bit_done && (bit_cnt == BIT_DATA_LAST)) w_next_state = PAR_EN ? ST_PARITY : ST_STOP;
        else                                          w_next_state = ST_DATA;
      end
      ST_PARITY: begin
        if (w_bit_done) w_next_state = par_err ? ST_IDLE : ST_STOP;
        else            w_next_state = ST_PARITY;
      end
      ST_STOP: begin
        if (w_bit_done) w_next_state = RX_IN ? ST_IDLE : ST_START;
        else            w_next_state = ST_STOP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dat_samp_en = (w_next_state != ST_IDLE);
    w_strt_chk_en = (r_state == ST_START)  && w_at_samp_pre;
    w_deser_en    = (r_state == ST_DATA)   && w_at_samp_pre;
    w_par_chk_en  = (r_state == ST_PARITY) && w_at_samp_pre;
    w_stp_chk_en  = (r_state == ST_STOP)   && w_at_samp_pre;
    w_data_valid  = (r_state == ST_STOP)   && w_bit_done && !stp_err;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_dat_samp_en <= 1'b0;
      r_strt_chk_en <= 1'b0;
      r_deser_en    <= 1'b0;
      r_par_chk_en  <= 1'b0;
      r_stp_chk_en  <= 1'b0;
      r_data_valid  <= 1'b0;
    end else begin
      r_dat_samp_en <= w_dat_samp_en;
      r_strt_chk_en <= w_strt_chk_en;
      r_deser_en    <= w_deser_en;
      r_par_chk_en  <= w_par_chk_en;
      r_stp_chk_en  <= w_stp_chk_en;
      r_data_valid  <= w_data_valid;
    end
  end

  assign dat_samp_en = r_dat_samp_en;
  assign strt_chk_en = r_strt_chk_en;
  assign deser_en    = r_deser_en;
  assign par_chk_en  = r_par_chk_en;
  assign stp_chk_en  = r_stp_chk_en;
  assign data_valid  = r_data_valid;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives whole frames bit by bit and checks
// counters, strobes and data_valid every cycle against hand-derived timing.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_dv = 0;
  int first_dv = 0;

  uart_rx_fsm #(.PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .deser_en(deser_en), .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid});
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, outs(), 32'd0);
    check({tag, "_edge"}, 32'(edge_cnt), 32'd0);
    check({tag, "_bit"}, 32'(bit_cnt), 32'd0);
  endtask

  function automatic logic line_bit(input int b, input logic [7:0] data, input bit pen);
    if (b == 0) return 1'b0;
    else if (b <= 8) return data[b-1];
    else if (b == 9 && pen) return ^data;
    else return 1'b1;
  endfunction

  task automatic run_frame(input int p, input bit pen, input logic [7:0] data, input bit glitch,
                           input bit perr, input bit serr, input bit b2b, input bit from_b2b);
    int s, nend, stop_bit, b, e, n_deser, start_cyc;
    logic exp_good;
    logic [31:0] exp_outs;
    s = p / 2 + 2;
    stop_bit = pen ? 10 : 9;
    if (glitch) nend = p;
    else if (perr) nend = 10 * p;
    else nend = (stop_bit + 1) * p;
    exp_good = !glitch && !perr && !serr;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    PAR_EN = pen;
    Prescale = 6'(p);
    if (!from_b2b) begin
      RX_IN = 1'b0;
      tick();
    end
    start_cyc = cyc;
    n_deser = 0;
    for (int k = 0; k < nend; k++) begin
      b = k / p;
      e = k % p;
      exp_outs = 32'({1'b1, (b == 0 && e == s), (b >= 1 && b <= 8 && e == s),
                      (pen && b == 9 && e == s), (b == stop_bit && e == s), (from_b2b && k == 0)});
      check("frame_strobes", outs(), exp_outs);
      check("frame_edge", 32'(edge_cnt), 32'(e));
      check("frame_bit", 32'(bit_cnt), 32'(b));
      if (deser_en) n_deser++;
      if (k == 1) Prescale = (p == 8) ? 6'd32 : 6'd8;
      if (e == s + 1) begin
        if (b == 0) strt_glitch = glitch;
        if (b == 9 && pen) par_err = perr;
        if (b == stop_bit) stp_err = serr;
      end
      RX_IN = (k == nend - 1) ? !b2b : line_bit(b, data, pen);
      tick();
    end
    check("deser_count", 32'(n_deser), glitch ? 32'd0 : 32'd8);
    check("end_outs", outs(), 32'({b2b, 4'b0000, exp_good}));
    check("end_edge", 32'(edge_cnt), 32'd0);
    check("end_bit", 32'(bit_cnt), 32'd0);
    if (exp_good) begin
      check("dv_latency", 32'(cyc - start_cyc), 32'(nend));
      last_dv = cyc;
    end
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    RX_IN = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check_zero(tag);
    end
  endtask

  initial begin
    // Reset held with a toggling line, then released while idle.
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RX_IN = i[0];
      tick();
      check_zero("reset_hold");
    end
    RST = 1'b1;
    idle_cycles(3, "reset_release");

    // Clean frame, P=8 with parity, 0xA5: data_valid 88 cycles after first START cycle.
    run_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, "after_clean");

    // Start glitch at P=16.
    run_frame(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, "after_glitch");

    // Parity error at P=8.
    run_frame(8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(10, "after_parerr");

    // Stop error, no parity, P=32.
    run_frame(32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(3, "after_stperr");

    // Two back-to-back frames at P=8 without parity.
    run_frame(8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    first_dv = last_dv;
    run_frame(8, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_spacing", 32'(last_dv - first_dv), 32'd80);
    idle_cycles(2, "after_b2b");

    // Reset in the middle of data bit 4.
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) tick();
    check("midframe_bit", 32'(bit_cnt), 32'd4);
    check("midframe_samp", 32'(dat_samp_en), 32'd1);
    RST = 1'b0;
    tick();
    check_zero("midframe_reset");
    RST = 1'b1;
    idle_cycles(2, "post_reset");

    // Fresh frame after the aborted one.
    run_frame(16, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
